maze_walker: RTL and testbench

- Initiator for the 16x16 single-bit maze memory. Drives its RD/WR/X/Y interface and consumes its one-bit read data.
- Performs a depth-first search from a start cell to a target cell. Cell value 0 means free and 1 means blocked.
- Marks every entered cell by writing 1, so cells are never re-entered.
- Keeps the move history on an internal direction stack, readable after completion as the solution path.

---
 rtl/maze_walker.sv | 173 +++++++++++++++++
 tb/tb_maze_walker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_walker.sv
// Depth-first maze solver that drives a 16x16 one-bit maze memory.
// Entered cells are marked with a write. The move history is kept on a direction stack.
module maze_walker #(
  parameter logic [3:0] START_X     = 4'd0,
  parameter logic [3:0] START_Y     = 4'd0,
  parameter logic [3:0] TARGET_X    = 4'd15,
  parameter logic [3:0] TARGET_Y    = 4'd15,
  parameter int         STACK_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mem_data,
  output logic       RD,
  output logic       WR,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len,
  input  logic [7:0] path_rd_idx,
  output logic [1:0] path_rd_dir
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_PICK  = 3'd2,
    S_READ  = 3'd3,
    S_CHECK = 3'd4,
    S_BACK  = 3'd5,
    S_DONE  = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  state_t state, state_nx;

  logic [3:0]    cur_x, cur_y, probe_x, probe_y;
  logic [2:0]    try_dir;
  logic [8:0]    len_q;
  logic [1:0]    stack [STACK_DEPTH];
  logic [1:0]    top_dir;
  logic [AW-1:0] top_idx;
  logic signed [4:0] nb_x, nb_y;
  logic          nb_oob, at_target, stack_full, free_cell;

  // Neighbour in direction try_dir, widened to 5-bit signed so -1 and 16 are detectable.
  always_comb begin
    nb_x = signed'({1'b0, cur_x});
    nb_y = signed'({1'b0, cur_y});
    case (try_dir[1:0])
      2'd0: nb_x = nb_x + 5'sd1;
      2'd1: nb_y = nb_y + 5'sd1;
      2'd2: nb_x = nb_x - 5'sd1;
      default: nb_y = nb_y - 5'sd1;
    endcase
    nb_oob = (nb_x < 5'sd0) || (nb_x > 5'sd15) || (nb_y < 5'sd0) || (nb_y > 5'sd15);
  end

  assign at_target  = (cur_x == TARGET_X) && (cur_y == TARGET_Y);
  assign stack_full = (len_q == 9'(STACK_DEPTH));
  assign free_cell  = !mem_data;
  assign top_idx    = AW'(len_q - 9'd1);
  assign top_dir    = stack[top_idx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) state_nx = S_MARK;
      S_MARK:  state_nx = at_target ? S_DONE : S_PICK;
      S_PICK: begin
        if (try_dir[2])   state_nx = S_BACK;
        else if (!nb_oob) state_nx = S_READ;
      end
      S_READ:  state_nx = S_CHECK;
      S_CHECK: begin
        if (free_cell) state_nx = stack_full ? S_FAIL : S_MARK;
        else           state_nx = S_PICK;
      end
      S_BACK:  state_nx = (len_q == 9'd0) ? S_FAIL : S_PICK;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    RD       = (state == S_READ);
    WR       = (state == S_MARK);
    X        = (state == S_READ) ? probe_x : cur_x;
    Y        = (state == S_READ) ? probe_y : cur_y;
    busy     = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    done     = (state == S_DONE);
    fail     = (state == S_FAIL);
    path_len = len_q;
  end

  // Search datapath: current cell, probe, direction cursor and stack depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x   <= START_X;
      cur_y   <= START_Y;
      probe_x <= START_X;
      probe_y <= START_Y;
      try_dir <= 3'd0;
      len_q   <= 9'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            cur_x   <= START_X;
            cur_y   <= START_Y;
            try_dir <= 3'd0;
            len_q   <= 9'd0;
          end
        end
        S_MARK: if (!at_target) try_dir <= 3'd0;
        S_PICK: begin
          if (!try_dir[2]) begin
            if (nb_oob) begin
              try_dir <= try_dir + 3'd1;
            end else begin
              probe_x <= nb_x[3:0];
              probe_y <= nb_y[3:0];
            end
          end
        end
        S_CHECK: begin
          if (free_cell && !stack_full) begin
            len_q <= len_q + 9'd1;
            cur_x <= probe_x;
            cur_y <= probe_y;
          end else if (free_cell) begin
            len_q <= 9'd0;
          end else begin
            try_dir <= try_dir + 3'd1;
          end
        end
        S_BACK: begin
          // Step back opposite to the popped move and resume at the next direction.
          if (len_q != 9'd0) begin
            len_q   <= len_q - 9'd1;
            try_dir <= {1'b0, top_dir} + 3'd1;
            case (top_dir)
              2'd0: cur_x <= cur_x - 4'd1;
              2'd1: cur_y <= cur_y - 4'd1;
              2'd2: cur_x <= cur_x + 4'd1;
              default: cur_y <= cur_y + 4'd1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CHECK && free_cell && !stack_full)
      stack[len_q[AW-1:0]] <= try_dir[1:0];
  end

  assign path_rd_dir = stack[path_rd_idx[AW-1:0]];

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: behavioural maze memory, protocol monitor
// and a scoreboard of per-run expected results.
module tb_maze_walker;

  localparam int         LIMIT    = 4000;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_BACK  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_data;
  logic       RD, WR;
  logic [3:0] X, Y;
  logic       busy, done, fail;
  logic [8:0] path_len;
  logic [7:0] path_rd_idx = 8'd0;
  logic [1:0] path_rd_dir;

  logic [255:0] mem;
  logic [255:0] img = '1;
  logic         load = 1'b0;
  logic [255:0] wr_seen = '0;
  logic         prev_rd = 1'b0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, back_cnt = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  maze_walker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_data(mem_data),
    .RD(RD), .WR(WR), .X(X), .Y(Y),
    .busy(busy), .done(done), .fail(fail), .path_len(path_len),
    .path_rd_idx(path_rd_idx), .path_rd_dir(path_rd_dir)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Maze memory: one-bit cells, read data valid the cycle after RD.
  always @(posedge clk) begin
    if (load) begin
      mem <= img;
    end else begin
      if (WR) mem[{Y, X}] <= 1'b1;
      if (RD) mem_data <= mem[{Y, X}];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Protocol monitor
  always @(negedge clk) begin
    if (load) begin
      wr_seen = '0;
      prev_rd = 1'b0;
    end else if (!rst_n) begin
      prev_rd = 1'b0;
    end else begin
      if (RD || WR) check("rd_wr_excl", 32'(RD & WR), 32'd0);
      if (prev_rd) begin
        check("rd_one_cycle", 32'(RD), 32'd0);
        check("rd_then_check", 32'(dut.state == ST_CHECK), 32'd1);
      end
      if (WR) begin
        check("wr_twice", 32'(wr_seen[{Y, X}]), 32'd0);
        wr_seen[{Y, X}] = 1'b1;
        wr_cnt++;
      end
      if (RD) rd_cnt++;
      if (dut.state == ST_BACK) back_cnt++;
      prev_rd = RD;
    end
  end

  // Driver tasks
  task automatic load_maze(input int scen);
    logic [255:0] m;
    m = '1;
    for (int i = 0; i < 16; i++) begin
      case (scen)
        1: begin m[i] = 1'b0; m[i*16 + 15] = 1'b0; end
        2: begin m[i*16] = 1'b0; m[240 + i] = 1'b0; if (i < 4) m[i] = 1'b0; end
        default: ;
      endcase
    end
    if (scen == 3) begin
      m = '0;
      m[1]  = 1'b1;
      m[16] = 1'b1;
    end
    @(negedge clk);
    img  = m;
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_search(input int extra_at, output int busy_cyc);
    int cyc;
    cyc = 0;
    busy_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      start = (extra_at != 0) && (cyc == extra_at);
      if (busy) busy_cyc++;
    end while (!(done || fail) && cyc < LIMIT);
    start = 1'b0;
    check("timeout", 32'(cyc >= LIMIT), 32'd0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_RD"}, 32'(RD), 32'd0);
    check({pfx, "_WR"}, 32'(WR), 32'd0);
    check({pfx, "_X"}, 32'(X), 32'd0);
    check({pfx, "_Y"}, 32'(Y), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_fail"}, 32'(fail), 32'd0);
    check({pfx, "_path_len"}, 32'(path_len), 32'd0);
  endtask

  // Scoreboard
  task automatic push(input string t, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic expect_run(input logic d, input logic f, input int len,
                            input int wr, input int rd, input int bk);
    push("done", 16'(d));
    push("fail", 16'(f));
    push("path_len", 16'(len));
    push("wr_pulses", 16'(wr));
    push("rd_pulses", 16'(rd));
    push("back_steps", 16'(bk));
  endtask

  task automatic expect_dirs(input int n, input logic [1:0] d);
    for (int i = 0; i < n; i++) push("dir", 16'(d));
  endtask

  task automatic score_run(input int wr0, input int rd0, input int bk0);
    logic [15:0] e;
    string t;
    int di;
    di = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (t == "done")            check(t, 32'(done), 32'(e));
      else if (t == "fail")       check(t, 32'(fail), 32'(e));
      else if (t == "path_len")   check(t, 32'(path_len), 32'(e));
      else if (t == "wr_pulses")  check(t, 32'(wr_cnt - wr0), 32'(e));
      else if (t == "rd_pulses")  check(t, 32'(rd_cnt - rd0), 32'(e));
      else if (t == "back_steps") check(t, 32'(back_cnt - bk0), 32'(e));
      else begin
        @(negedge clk);
        path_rd_idx = 8'(di);
        #1;
        check($sformatf("dir%0d", di), 32'(path_rd_dir), 32'(e));
        di++;
      end
    end
  endtask

  task automatic corridor_run(input int extra_at);
    int wr0, rd0, bk0, bc;
    load_maze(1);
    expect_run(1'b1, 1'b0, 30, 31, 30, 0);
    expect_dirs(15, 2'd0);
    expect_dirs(15, 2'd1);
    wr0 = wr_cnt; rd0 = rd_cnt; bk0 = back_cnt;
    run_search(extra_at, bc);
    score_run(wr0, rd0, bk0);
  endtask

  initial begin
    int wr0, rd0, bk0, bc;

    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Straight corridor: right along row 0, then down column 15
    corridor_run(0);

    // Dead-end spur on row 0 forces three backtracks before column 0 / row 15
    load_maze(2);
    expect_run(1'b1, 1'b0, 30, 34, 54, 3);
    expect_dirs(15, 2'd1);
    expect_dirs(15, 2'd0);
    wr0 = wr_cnt; rd0 = rd_cnt; bk0 = back_cnt;
    run_search(0, bc);
    score_run(wr0, rd0, bk0);

    // Enclosed start: MARK, two probes, two boundary skips, exhaust, BACK -> 11 busy cycles
    load_maze(3);
    expect_run(1'b0, 1'b1, 0, 1, 2, 1);
    wr0 = wr_cnt; rd0 = rd_cnt; bk0 = back_cnt;
    run_search(0, bc);
    check("busy_cycles", 32'(bc), 32'd11);
    score_run(wr0, rd0, bk0);

    // Asynchronous reset in the middle of a corridor search, then a clean rerun
    load_maze(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    corridor_run(0);

    // Second start while busy must be ignored
    corridor_run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
